// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        SIGN   = 3'd0,
        ZERO   = 3'd1,
        UPPER  = 3'd2,
        BRANCH = 3'd3
    } ext_mode_t;

    // Any mode code at or above this value is illegal.
    localparam logic [2:0] EXT_ILLEGAL_MIN = 3'd4;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry FIFO with 1-bit wrapping pointers; ready depends on registered occupancy only.
module ext_skid_buf #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [DW-1:0] o_rd_data
);

    // Handshake: a beat transfers on a rising clk when valid && ready; a held
    // valid keeps its data stable until ready, and ready never depends on valid.
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign o_wr_ready = (r_count != 2'd2);
    assign o_rd_valid = (r_count != 2'd0);
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = o_rd_valid && i_rd_ready;
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender: extends at accept time, buffers {err, data} in a 2-entry FIFO,
// and keeps a saturating count of illegal-mode transactions.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    generate
        if (OUT_W < IN_W + BR_SHIFT) begin : g_bad_params
            $error("imm_extend_pipe: OUT_W must be >= IN_W + BR_SHIFT");
        end
    endgenerate

    // Result layout is {err, data}; illegal modes yield data 0.
    function automatic logic [OUT_W:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [2:0]      mode);
        logic [OUT_W-1:0] v_sext;
        logic [OUT_W-1:0] v_zext;
        v_sext     = OUT_W'($signed(imm));
        v_zext     = OUT_W'(imm);
        extend_imm = {1'b1, {OUT_W{1'b0}}};
        if (mode < EXT_ILLEGAL_MIN) begin
            case (ext_mode_t'(mode))
                SIGN:    extend_imm = {1'b0, v_sext};
                ZERO:    extend_imm = {1'b0, v_zext};
                UPPER:   extend_imm = {1'b0, v_zext << (OUT_W - IN_W)};
                BRANCH:  extend_imm = {1'b0, v_sext << BR_SHIFT};
                default: extend_imm = {1'b1, {OUT_W{1'b0}}};
            endcase
        end
    endfunction

    logic [OUT_W:0]   w_ext;
    logic [OUT_W:0]   w_rd_data;
    logic             w_accept;
    logic [CNT_W-1:0] r_err_count;

    assign w_ext     = extend_imm(in_imm, in_mode);
    assign w_accept  = in_valid && in_ready;
    assign out_data  = w_rd_data[OUT_W-1:0];
    assign out_err   = w_rd_data[OUT_W];
    assign err_count = r_err_count;

    ext_skid_buf #(
        .DW(OUT_W + 1)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .i_wr_valid (in_valid),
        .o_wr_ready (in_ready),
        .i_wr_data  (w_ext),
        .o_rd_valid (out_valid),
        .i_rd_ready (out_ready),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_ext[OUT_W] && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against an arithmetic reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_count;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_imm;
    logic [2:0]  b_in_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_out_data;
    logic        b_out_err;
    logic [7:0]  b_err_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    int          exp_errs = 0;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_count(err_count)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1), .CNT_W(8)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err(b_out_err), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: extension rules stated as plain integer arithmetic.
    function automatic longint unsigned ref_ext(input longint unsigned imm, input int mode,
                                                input int iw, input int ow, input int sh,
                                                output bit err);
        longint unsigned mask;
        longint unsigned sext;
        mask = (64'd1 << ow) - 1;
        sext = imm;
        if (((imm >> (iw - 1)) & 1) == 1) sext = imm + ((64'd1 << ow) - (64'd1 << iw));
        err = 1'b0;
        case (mode)
            0:       return sext & mask;
            1:       return imm;
            2:       return (imm * (64'd1 << (ow - iw))) & mask;
            3:       return (sext * (64'd1 << sh)) & mask;
            default: begin err = 1'b1; return 0; end
        endcase
    endfunction

    // One clock: check outputs against the model at negedge, drive, advance the model.
    task automatic cycle(input bit iv, input logic [2:0] md, input logic [15:0] im, input bit ordy);
        bit acc;
        bit emi;
        bit err;
        longint unsigned d;
        @(negedge clk);
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0][31:0]);
            chk("out_err", out_err, exp_q[0][32]);
        end
        chk("err_count", err_count, exp_errs);
        in_valid  = iv;
        in_mode   = md;
        in_imm    = im;
        out_ready = ordy;
        acc = iv && (exp_q.size() < 2);
        emi = (exp_q.size() != 0) && ordy;
        if (emi) void'(exp_q.pop_front());
        if (acc) begin
            d = ref_ext(im, md, 16, 32, 2, err);
            exp_q.push_back({err, d[31:0]});
            if (err && exp_errs < 255) exp_errs++;
        end
        @(posedge clk);
    endtask

    initial begin
        bit err;
        longint unsigned d;
        reset = 1'b1;
        in_valid = 0; in_imm = 0; in_mode = 0; out_ready = 0;
        b_in_valid = 0; b_in_imm = 0; b_in_mode = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic modes, one transaction each with downstream always ready.
        cycle(1, 3'd0, 16'h8001, 1); #1 chk("sign_8001", out_data, 32'hFFFF8001);
        chk("sign_err", out_err, 0);
        cycle(1, 3'd1, 16'h8001, 1); #1 chk("zero_8001", out_data, 32'h00008001);
        cycle(1, 3'd2, 16'h1234, 1); #1 chk("upper_1234", out_data, 32'h12340000);
        cycle(1, 3'd3, 16'hFFFF, 1); #1 chk("branch_ffff", out_data, 32'hFFFFFFFC);
        cycle(0, 3'd0, 16'h0000, 1); #1 chk("drained", out_valid, 0);

        // Backpressure: third transaction waits until space frees up.
        cycle(1, 3'd0, 16'd1, 0);
        cycle(1, 3'd0, 16'd2, 0); #1 chk("full_in_ready", in_ready, 0);
        chk("full_head", out_data, 32'd1);
        cycle(1, 3'd0, 16'd3, 0);
        cycle(1, 3'd0, 16'd3, 1); #1 chk("order_2", out_data, 32'd2);
        cycle(1, 3'd0, 16'd3, 1); #1 chk("order_3", out_data, 32'd3);
        cycle(0, 3'd0, 16'd0, 1); #1 chk("order_empty", out_valid, 0);

        // Narrow instance: IN_W=8, OUT_W=16, BR_SHIFT=1.
        @(negedge clk);
        b_in_valid = 1; b_in_mode = 3'd0; b_in_imm = 8'h80;
        @(posedge clk); #1 chk("small_sign_80", b_out_data, 16'hFF80);
        d = ref_ext(8'h80, 0, 8, 16, 1, err);
        chk("small_sign_model", b_out_data, d);
        @(negedge clk);
        b_in_mode = 3'd3; b_in_imm = 8'h81;
        @(posedge clk); #1 chk("small_branch_81", b_out_data, 16'hFF02);
        d = ref_ext(8'h81, 3, 8, 16, 1, err);
        chk("small_branch_model", b_out_data, d);
        @(negedge clk);
        b_in_valid = 0;

        // Illegal mode and counter saturation.
        cycle(1, 3'd5, 16'h00FF, 1); #1 chk("illegal_data", out_data, 0);
        chk("illegal_err", out_err, 1);
        chk("illegal_cnt1", err_count, 1);
        for (int i = 0; i < 300; i++) cycle(1, 3'($urandom_range(4, 7)), 16'($urandom), 1);
        #1 chk("err_sat", err_count, 255);

        // Asynchronous reset with two entries held.
        cycle(0, 3'd0, 16'd0, 1);
        cycle(1, 3'd0, 16'h1111, 0);
        cycle(1, 3'd1, 16'h2222, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_err_count", err_count, 0);
        chk("arst_out_data", out_data, 0);
        exp_q.delete();
        exp_errs = 0;
        @(negedge clk);
        in_valid = 0;
        reset = 1'b0;

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 3'd0, 16'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
